glip_osd_reg_reader: RTL and testbench
======================================

GLIP_OSD_REG_READER -- requirements
Module: glip_osd_reg_reader

Interface
REQ-001 SHALL have parameter SRC_ID, default 16'h0001, the debug-interconnect address of this host endpoint, placed in the src word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, the number of cycles to wait for a response after the last request word is sent.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 req_dest  input  16  target debug module address.
REQ-007 req_addr  input  16  target register address.
REQ-008 busy  output  1  high from the accepted start until DONE is left.
REQ-009 done  output  1  one-cycle pulse when a transaction ends.
REQ-010 rsp_data  output  16  read data, valid while done=1, then held.
REQ-011 rsp_status  output  2  0=OK, 1=module error response, 2=timeout; valid while done=1.
REQ-012 out_data / out_valid / out_ready  output / output / input  16/1/1  GLIP word stream toward the system (system c_glip_in).
REQ-013 in_data / in_valid / in_ready  input / input / output  16/1/1  GLIP word stream from the system (system c_glip_out).

Function
REQ-014 Each GLIP word SHALL transfer only in a cycle with valid=1 and ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 The FSM SHALL have states IDLE, TX, WAIT, RX, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL latch req_dest/req_addr, clear the word counter and move to TX next cycle; busy rises that same cycle.
REQ-017 TX SHALL send 5 words in order: 16'd4 (length), req_dest, SRC_ID, 16'h0000 (flags: TYPE=REG, SUB=REQ_READ_REG_16), req_addr.
REQ-018 After the 5th accepted word, the FSM SHALL enter WAIT with the timeout counter cleared.
REQ-019 in_ready SHALL be 1 in WAIT, RX and DRAIN, and 0 in IDLE, TX and DONE.
REQ-020 WAIT: an accepted word SHALL be latched as the packet length L; L=4 -> RX; L=0 -> stay in WAIT; any other L -> DRAIN to discard L words.
REQ-021 RX SHALL check the following words: dest==SRC_ID and src==latched req_dest; a mismatch SHALL discard the remaining words of the packet and return to WAIT.
REQ-022 RX flags word: bits[15:14]==0 and bits[13:10]==4'd8 -> success; ==4'd12 -> error; any other value SHALL be treated as a mismatch (REQ-021).
REQ-023 The 4th payload word SHALL be latched into rsp_data; after it the FSM SHALL enter DONE with rsp_status 0 (success) or 1 (error).
REQ-024 The timeout counter SHALL increment every cycle in WAIT, RX and DRAIN; reaching TIMEOUT_CYCLES-1 SHALL force DONE with rsp_status=2 and rsp_data unchanged.
REQ-025 If a word is accepted in the same cycle the timeout fires, the timeout SHALL win and the word is consumed and discarded.
REQ-026 DONE SHALL last exactly one cycle: done=1 that cycle, then IDLE with busy=0; start in DONE SHALL be ignored.
REQ-027 Minimum latency SHALL be start -> done = 11 cycles with ready/valid held high (1 latch + 5 TX + 5 RX words).
REQ-028 The word counter (3 bits) and timeout counter (width $clog2(TIMEOUT_CYCLES)+1) SHALL not wrap; the drain counter SHALL be 16 bits.

Reset
REQ-029 While rst=0: state=IDLE, busy=0, done=0, out_valid=0, in_ready=0, rsp_data=0, rsp_status=0, all counters 0.
REQ-030 A reset asserted mid-transaction SHALL abandon it with no done pulse; partially sent packets are not completed.

Structure
REQ-031 The length-word value, TYPE/SUB encodings (REQ_READ_REG_16=0, RESP_SUCCESS_16=8, RESP_ERROR=12) and the status enum SHALL live in a shared package (osd_host_pkg).
REQ-032 Sub-module glip_osd_rx_parser (WAIT/RX/DRAIN word handling) is natural; TX and the top FSM stay in the top module.

Verification
REQ-033 Responder stub, req_dest=16'h0005, req_addr=16'h0200, reply words 4,0001,0005,2000,BEEF -> done after 11 cycles, rsp_data=16'hBEEF, status 0.
REQ-034 out_ready toggling 0/1 every cycle -> the same 5 request words are sent in order, and out_data is stable while stalled.
REQ-035 Stray packet 3,0001,0009,0000 followed by a valid response -> the stray packet is drained, then status 0 with the correct data.
REQ-036 Error reply with flags 16'h3000 -> status 1.
REQ-037 No reply with TIMEOUT_CYCLES=64 -> done exactly 64 cycles after WAIT is entered, status 2.
REQ-038 rst pulled low during RX, then released -> busy=0, no done; a new start completes normally.

Source files
------------

// File: rtl/osd_host_pkg.sv
// Shared OSD host definitions: packet constants, TYPE/SUB encodings, status and FSM enums.
package osd_host_pkg;

  localparam logic [15:0] OSD_REQ_LEN = 16'd4;
  localparam logic [15:0] OSD_RSP_LEN = 16'd4;

  localparam logic [1:0] TYPE_REG            = 2'd0;
  localparam logic [3:0] SUB_REQ_READ_REG_16 = 4'd0;
  localparam logic [3:0] SUB_RESP_SUCCESS_16 = 4'd8;
  localparam logic [3:0] SUB_RESP_ERROR      = 4'd12;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_ERR     = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_WAIT, S_RX, S_DRAIN, S_DONE
  } state_e;

  function automatic logic [15:0] osd_flags(input logic [1:0] typ, input logic [3:0] sub);
    return {typ, sub, 10'b0};
  endfunction

endpackage

// File: rtl/glip_osd_rx_parser.sv
// Response-side word handling for the register reader: length, header checks and discard.
module glip_osd_rx_parser
  import osd_host_pkg::*;
#(
  parameter logic [15:0] SRC_ID = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  state_e      state_i,
  input  logic [15:0] req_dest_i,
  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  output state_e      next_o,
  output logic        fin_o,
  output logic        fin_err_o
);

  logic [1:0]  idx_q, idx_d;
  logic [15:0] drain_q, drain_d;
  logic        err_q, err_d;
  logic        acc, mismatch;

  assign in_ready_o = state_i inside {S_WAIT, S_RX, S_DRAIN};
  assign acc        = in_valid_i & in_ready_o;
  assign fin_err_o  = err_q;

  always_comb begin
    next_o   = state_i;
    idx_d    = idx_q;
    drain_d  = drain_q;
    err_d    = err_q;
    fin_o    = 1'b0;
    mismatch = 1'b0;
    case (state_i)
      S_WAIT: if (acc) begin
        if (in_data_i == OSD_RSP_LEN) begin
          next_o = S_RX;
          idx_d  = 2'd0;
        end else if (in_data_i != 16'd0) begin
          next_o  = S_DRAIN;
          drain_d = in_data_i;
        end
      end
      S_RX: if (acc) begin
        case (idx_q)
          2'd0: mismatch = (in_data_i != SRC_ID);
          2'd1: mismatch = (in_data_i != req_dest_i);
          2'd2: begin
            if (in_data_i[15:10] == {TYPE_REG, SUB_RESP_SUCCESS_16}) err_d = 1'b0;
            else if (in_data_i[15:10] == {TYPE_REG, SUB_RESP_ERROR}) err_d = 1'b1;
            else mismatch = 1'b1;
          end
          default: begin
            fin_o  = 1'b1;
            next_o = S_DONE;
          end
        endcase
        // A rejected header discards the rest of its 4-word packet
        if (mismatch) begin
          next_o  = S_DRAIN;
          drain_d = {14'd0, 2'd3 - idx_q};
        end else if (idx_q != 2'd3) begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DRAIN: if (acc) begin
        drain_d = drain_q - 16'd1;
        if (drain_q == 16'd1) next_o = S_WAIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= 2'd0;
      drain_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/glip_osd_reg_reader.sv
// Host-side OSD 16-bit register reader: sends a READ_REG_16 request over GLIP and awaits the reply.
module glip_osd_reg_reader
  import osd_host_pkg::*;
#(
  parameter logic [15:0] SRC_ID         = 16'h0001,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] req_dest,
  input  logic [15:0] req_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d, rx_next;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   dest_q, dest_d, addr_q, addr_d, data_q, data_d;
  logic [1:0]    status_q, status_d;
  logic          rx_active, timeout, fin, fin_err;

  function automatic logic [15:0] tx_word(input logic [2:0] idx, input logic [15:0] dest,
                                          input logic [15:0] addr);
    case (idx)
      3'd0:    return OSD_REQ_LEN;
      3'd1:    return dest;
      3'd2:    return SRC_ID;
      3'd3:    return osd_flags(TYPE_REG, SUB_REQ_READ_REG_16);
      3'd4:    return addr;
      default: return 16'd0;
    endcase
  endfunction

  glip_osd_rx_parser #(.SRC_ID(SRC_ID)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .state_i    (state_q),
    .req_dest_i (dest_q),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .next_o     (rx_next),
    .fin_o      (fin),
    .fin_err_o  (fin_err)
  );

  assign rx_active  = state_q inside {S_WAIT, S_RX, S_DRAIN};
  assign timeout    = rx_active && (tcnt_q == TLAST);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_valid  = (state_q == S_TX);
  assign out_data   = tx_word(wcnt_q, dest_q, addr_q);
  assign rsp_data   = data_q;
  assign rsp_status = status_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    dest_d   = dest_q;
    addr_d   = addr_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: if (start) begin
        dest_d  = req_dest;
        addr_d  = req_addr;
        wcnt_d  = 3'd0;
        state_d = S_TX;
      end
      S_TX: if (out_ready) begin
        wcnt_d = wcnt_q + 3'd1;
        if (wcnt_q == 3'd4) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end
      end
      S_WAIT, S_RX, S_DRAIN: begin
        if (tcnt_q != TLAST) tcnt_d = tcnt_q + TW'(1);
        // Timeout takes priority over a word accepted in the same cycle
        if (timeout) begin
          state_d  = S_DONE;
          status_d = STATUS_TIMEOUT;
        end else begin
          state_d = rx_next;
          if (fin) begin
            data_d   = in_data;
            status_d = fin_err ? STATUS_ERR : STATUS_OK;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 3'd0;
      tcnt_q   <= '0;
      data_q   <= 16'd0;
      status_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    addr_q <= addr_d;
  end

endmodule

// File: tb/tb_glip_osd_reg_reader.sv
// Testbench for glip_osd_reg_reader: directed vector table, randomized replies against a packet-level model.
module tb_glip_osd_reg_reader;

  localparam logic [15:0] SRC = 16'h0001;
  localparam int          TO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] req_dest = 16'd0, req_addr = 16'd0;
  logic        busy, done;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;

  glip_osd_reg_reader #(.SRC_ID(SRC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .req_dest(req_dest), .req_addr(req_addr),
    .busy(busy), .done(done), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] reply_q[$];
  int          or_mode = 0;
  int          iv_mode = 0;
  bit          poke = 1'b0;
  logic [15:0] model_data = 16'd0;
  int          res_lat;
  logic [1:0]  res_st;
  logic [15:0] res_dt;

  // Packet-level reference: find the word completing the first acceptable response
  function automatic void ref_parse(input logic [15:0] dest, output int idx,
                                    output logic [1:0] st, output logic [15:0] dt);
    int p, len;
    logic [15:0] f;
    p = 0; idx = -1; st = 2'd2; dt = 16'd0;
    while (p < reply_q.size()) begin
      len = int'(reply_q[p]);
      p++;
      if (len != 4) begin
        p += len;
        continue;
      end
      if (p + 3 >= reply_q.size()) break;
      f = reply_q[p+2];
      if (reply_q[p] == SRC && reply_q[p+1] == dest && f[15:14] == 2'b00 &&
          (f[13:10] == 4'd8 || f[13:10] == 4'd12)) begin
        idx = p + 3;
        st  = (f[13:10] == 4'd12) ? 2'd1 : 2'd0;
        dt  = reply_q[p+3];
        return;
      end
      p += 4;
    end
  endfunction

  task automatic run_txn(input logic [15:0] dest, input logic [15:0] addr);
    logic [15:0] txw[5];
    int          comp_idx, n_out, n_in, w_ent, d_cyc, k;
    logic [1:0]  pst, fst;
    logic [15:0] pdt, fdt;
    bit          got;
    ref_parse(dest, comp_idx, pst, pdt);
    txw = '{16'd4, dest, SRC, 16'h0000, addr};
    start = 1'b1; req_dest = dest; req_addr = addr;
    step();
    start = 1'b0; req_dest = 16'($urandom); req_addr = 16'($urandom);
    n_out = 0; n_in = 0; w_ent = -1; d_cyc = -1; got = 1'b0;
    fst = 2'd0; fdt = model_data; res_lat = -1; res_st = 2'd3; res_dt = 16'd0;
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("out_valid", 32'(out_valid), 32'(n_out < 5));
      if (n_out < 5) chk("out_data", 32'(out_data), 32'(txw[n_out]));
      chk("in_ready", 32'(in_ready), 32'(w_ent >= 0 && cyc >= w_ent && !(d_cyc >= 0 && cyc >= d_cyc)));
      chk("done", 32'(done), 32'(cyc == d_cyc));
      if (done) begin
        got = 1'b1; res_lat = cyc + 1; res_st = rsp_status; res_dt = rsp_data;
        chk("rsp_status", 32'(rsp_status), 32'(fst));
        chk("rsp_data", 32'(rsp_data), 32'(fdt));
      end
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      in_valid  = (n_in < reply_q.size()) && (iv_mode == 0 || $urandom_range(0, 3) != 0);
      in_data   = in_valid ? reply_q[n_in] : 16'($urandom);
      start     = got && poke;
      if (!got) begin
        if (n_out < 5) begin
          if (out_ready) begin
            n_out++;
            if (n_out == 5) w_ent = cyc + 1;
          end
        end else if (d_cyc < 0 && cyc >= w_ent) begin
          k = cyc - w_ent;
          if (in_valid) n_in++;
          if (k == TO - 1) begin
            d_cyc = cyc + 1; fst = 2'd2; fdt = model_data;
          end else if (in_valid && n_in - 1 == comp_idx) begin
            d_cyc = cyc + 1; fst = pst; fdt = pdt;
          end
        end
      end
      step();
    end
    if (!got) chk("done_seen", 32'd0, 32'd1);
    if (d_cyc >= 0 && fst != 2'd2) model_data = fdt;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("no_restart_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] dest;
    logic [15:0] addr;
    int          orm;
    int          nw;
    logic [15:0] w[12];
    logic [1:0]  st;
    logic [15:0] dt;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0].dest = 16'h0005; vecs[0].addr = 16'h0200; vecs[0].orm = 0; vecs[0].nw = 5;
    vecs[0].w = '{16'h4, 16'h1, 16'h5, 16'h2000, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[0].st = 2'd0; vecs[0].dt = 16'hBEEF; vecs[0].lat = 11;
    vecs[1].dest = 16'h0007; vecs[1].addr = 16'h0033; vecs[1].orm = 1; vecs[1].nw = 5;
    vecs[1].w = '{16'h4, 16'h1, 16'h7, 16'h2000, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[1].st = 2'd0; vecs[1].dt = 16'h1234; vecs[1].lat = 16;
    vecs[2].dest = 16'h0005; vecs[2].addr = 16'h0200; vecs[2].orm = 0; vecs[2].nw = 9;
    vecs[2].w = '{16'h3, 16'h1, 16'h9, 16'h0, 16'h4, 16'h1, 16'h5, 16'h2000, 16'hCAFE, 16'h0, 16'h0, 16'h0};
    vecs[2].st = 2'd0; vecs[2].dt = 16'hCAFE; vecs[2].lat = 15;
    vecs[3].dest = 16'h0005; vecs[3].addr = 16'h0010; vecs[3].orm = 0; vecs[3].nw = 5;
    vecs[3].w = '{16'h4, 16'h1, 16'h5, 16'h3000, 16'hDEAD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[3].st = 2'd1; vecs[3].dt = 16'hDEAD; vecs[3].lat = 11;
    vecs[4].dest = 16'h0005; vecs[4].addr = 16'h0010; vecs[4].orm = 0; vecs[4].nw = 0;
    vecs[4].w = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[4].st = 2'd2; vecs[4].dt = 16'hDEAD; vecs[4].lat = 70;
    vecs[5].dest = 16'h0005; vecs[5].addr = 16'h0011; vecs[5].orm = 0; vecs[5].nw = 10;
    vecs[5].w = '{16'h4, 16'h2, 16'h5, 16'h2000, 16'h1111, 16'h4, 16'h1, 16'h5, 16'h2000, 16'h5A5A, 16'h0, 16'h0};
    vecs[5].st = 2'd0; vecs[5].dt = 16'h5A5A; vecs[5].lat = 16;
    vecs[6].dest = 16'h0009; vecs[6].addr = 16'h0012; vecs[6].orm = 0; vecs[6].nw = 11;
    vecs[6].w = '{16'h4, 16'h1, 16'h9, 16'h4000, 16'h9999, 16'h0, 16'h4, 16'h1, 16'h9, 16'h2000, 16'h7777, 16'h0};
    vecs[6].st = 2'd0; vecs[6].dt = 16'h7777; vecs[6].lat = 17;
    vecs[7].dest = 16'h0009; vecs[7].addr = 16'h0013; vecs[7].orm = 0; vecs[7].nw = 10;
    vecs[7].w = '{16'h4, 16'h1, 16'h8, 16'h2000, 16'h2222, 16'h4, 16'h1, 16'h9, 16'h3400, 16'h3333, 16'h0, 16'h0};
    vecs[7].st = 2'd2; vecs[7].dt = 16'h7777; vecs[7].lat = 70;

    // Reset state
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    rst = 1'b1;
    step();

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      reply_q.delete();
      for (int j = 0; j < vecs[i].nw; j++) reply_q.push_back(vecs[i].w[j]);
      or_mode = vecs[i].orm; iv_mode = 0; poke = (i == 3);
      run_txn(vecs[i].dest, vecs[i].addr);
      chk($sformatf("vec%0d_latency", i), 32'(res_lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_status", i), 32'(res_st), 32'(vecs[i].st));
      chk($sformatf("vec%0d_data", i), 32'(res_dt), 32'(vecs[i].dt));
    end

    // Randomized replies against the packet model
    for (int t = 0; t < 30; t++) begin
      logic [15:0] dest;
      int np, len, kind;
      dest = 16'($urandom);
      reply_q.delete();
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        case ($urandom_range(0, 3))
          0: reply_q.push_back(16'd0);
          1, 3: begin
            len = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(5, 7);
            reply_q.push_back(16'(len));
            for (int j = 0; j < len; j++) reply_q.push_back(16'($urandom));
          end
          default: begin
            reply_q.push_back(16'd4);
            reply_q.push_back(($urandom_range(0, 1) != 0) ? SRC : 16'($urandom));
            reply_q.push_back(($urandom_range(0, 1) != 0) ? dest : 16'($urandom));
            reply_q.push_back(($urandom_range(0, 1) != 0) ? 16'h2000 : 16'($urandom));
            reply_q.push_back(16'($urandom));
          end
        endcase
      end
      kind = $urandom_range(0, 5);
      if (kind != 5) begin
        reply_q.push_back(16'd4);
        reply_q.push_back(SRC);
        reply_q.push_back(dest);
        reply_q.push_back((kind < 3) ? 16'h2000 : 16'h3000);
        reply_q.push_back(16'($urandom));
      end
      or_mode = $urandom_range(0, 2); iv_mode = $urandom_range(0, 1);
      poke = ($urandom_range(0, 1) != 0);
      run_txn(dest, 16'($urandom));
    end

    // Reset in the middle of the response, then a clean transaction
    reply_q = '{16'h4, 16'h1, 16'h5, 16'h2000, 16'h4242};
    or_mode = 0; iv_mode = 0; poke = 1'b0;
    run_txn(16'h0005, 16'h0100);
    chk("pre_reset_data", 32'(rsp_data), 32'h4242);
    start = 1'b1; req_dest = 16'h0005; req_addr = 16'h0101;
    step();
    start = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_data = (c < 5) ? 16'h0 : reply_q[c-5];
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_rst_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    model_data = 16'd0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    reply_q = '{16'h4, 16'h1, 16'h5, 16'h2000, 16'h0F0F};
    run_txn(16'h0005, 16'h0300);
    chk("post_rst_latency", 32'(res_lat), 32'd11);
    chk("post_rst_status", 32'(res_st), 32'd0);
    chk("post_rst_data", 32'(res_dt), 32'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
